// File: rtl/systolic_pkg.sv
// Shared types, default widths and requantisation helpers for the weight-stationary systolic engine.
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_e;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
    localparam int DEF_DW   = 8;
    localparam int DEF_AW   = 24;
    localparam int DEF_OW   = 8;
    localparam int DEF_SHW  = 5;

    function automatic longint sat_signed(input longint v, input int ow);
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (ow - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    // Arithmetic shift rounds toward -inf before clamping to the output range.
    function automatic longint requant(input longint acc, input int unsigned sh, input int ow);
        return sat_signed(acc >>> sh, ow);
    endfunction

endpackage

// File: rtl/systolic_array_ws_if.sv
// Weight, activation and result valid/ready channels of the systolic engine.
// slave = engine side, master = producer/consumer side.
interface systolic_array_ws_if
    import systolic_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int DW   = DEF_DW,
    parameter int OW   = DEF_OW,
    parameter int SHW  = DEF_SHW
) ();
    logic [SHW-1:0]     cfg_shift;
    logic               w_valid;
    logic               w_ready;
    logic [COLS*DW-1:0] w_data;
    logic               a_valid;
    logic               a_ready;
    logic [ROWS*DW-1:0] a_data;
    logic               a_last;
    logic               y_valid;
    logic               y_ready;
    logic [COLS*OW-1:0] y_data;
    logic               y_last;
    logic               busy;

    modport master (
        output cfg_shift, w_valid, w_data, a_valid, a_data, a_last, y_ready,
        input  w_ready, a_ready, y_valid, y_data, y_last, busy
    );

    modport slave (
        input  cfg_shift, w_valid, w_data, a_valid, a_data, a_last, y_ready,
        output w_ready, a_ready, y_valid, y_data, y_last, busy
    );
endinterface

// File: rtl/ws_pe.sv
// One weight-stationary PE: psum_out = psum_in + a*w, activation forwarded right; 1 cycle latency.
// Holds all pipeline state when en=0; the weight register is written independently of en.
module ws_pe #(
    parameter int DW = 8,
    parameter int AW = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 w_we,
    input  logic signed [DW-1:0] w_in,
    input  logic signed [DW-1:0] a_in,
    input  logic signed [AW-1:0] psum_in,
    output logic signed [DW-1:0] a_out,
    output logic signed [AW-1:0] psum_out
);
    logic signed [DW-1:0]   w_q;
    logic signed [2*DW-1:0] prod;

    assign prod = a_in * w_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       w_q <= '0;
        else if (w_we) w_q <= w_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out    <= '0;
            psum_out <= '0;
        end else if (en) begin
            a_out    <= a_in;
            psum_out <= psum_in + AW'(prod);
        end
    end
endmodule

// File: rtl/systolic_array_ws.sv
// ROWS x COLS weight-stationary matrix engine with input skew, output de-skew and shift/saturate requant; ROWS+COLS cycle latency.
// Whole pipeline freezes while a result is held unaccepted. SYSTOLIC_RELU_EN adds per-column ReLU after saturation.
module systolic_array_ws
    import systolic_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW,
    parameter int OW   = DEF_OW,
    parameter int SHW  = DEF_SHW
) (
    input logic              clk,
    input logic              rst,
    systolic_array_ws_if.slave bus
);
    localparam int DEPTH = ROWS + COLS;
    localparam int CW    = $clog2(ROWS + 1);
    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_LOAD   = 2'(LOAD);
    localparam logic [1:0] S_STREAM = 2'(STREAM);
    localparam logic [1:0] S_DRAIN  = 2'(DRAIN);

    if (AW < 2*DW + $clog2(ROWS)) begin : g_aw_chk
        $error("AW too narrow to hold ROWS accumulated DW x DW products");
    end

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      wrow;
    logic [SHW-1:0]     shift_q;
    logic               adv, w_fire, a_fire;
    logic               y_valid_q, y_last_q;
    logic [COLS*OW-1:0] y_data_q, y_nxt;
    logic [DEPTH-1:0]   vld_p, last_p;

    logic signed [DW-1:0] a_in_q [ROWS];
    logic signed [DW-1:0] row_a  [ROWS];
    logic signed [DW-1:0] ah     [ROWS][COLS];
    logic signed [AW-1:0] ps     [ROWS][COLS];
    logic signed [AW-1:0] col_acc[COLS];

    assign adv         = !(y_valid_q && !bus.y_ready);
    assign bus.w_ready = (state == S_IDLE) || (state == S_LOAD);
    assign bus.a_ready = (state == S_STREAM) && adv;
    assign bus.busy    = (state != S_IDLE);
    assign bus.y_valid = y_valid_q;
    assign bus.y_last  = y_last_q;
    assign bus.y_data  = y_data_q;
    assign w_fire      = bus.w_valid && bus.w_ready;
    assign a_fire      = bus.a_valid && bus.a_ready;
    assign wrow        = (state == S_IDLE) ? '0 : cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            shift_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (w_fire) begin
                    shift_q <= bus.cfg_shift;
                    cnt     <= CW'(1);
                    state   <= (ROWS == 1) ? S_STREAM : S_LOAD;
                end
                S_LOAD: if (w_fire) begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ROWS - 1)) state <= S_STREAM;
                end
                S_STREAM: if (a_fire && bus.a_last) state <= S_DRAIN;
                S_DRAIN:  if (y_valid_q && bus.y_ready && y_last_q) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Input register, valid/last pipes and output register all advance together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p     <= '0;
            last_p    <= '0;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
            y_data_q  <= '0;
            for (int r = 0; r < ROWS; r++) a_in_q[r] <= '0;
        end else if (adv) begin
            vld_p     <= {vld_p[DEPTH-2:0], a_fire};
            last_p    <= {last_p[DEPTH-2:0], a_fire && bus.a_last};
            y_valid_q <= vld_p[DEPTH-1];
            y_last_q  <= last_p[DEPTH-1];
            y_data_q  <= y_nxt;
            for (int r = 0; r < ROWS; r++)
                a_in_q[r] <= a_fire ? bus.a_data[r*DW +: DW] : '0;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign row_a[r] = a_in_q[r];
        end else begin : g_delay
            logic signed [DW-1:0] sr [r];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < r; i++) sr[i] <= '0;
                end else if (adv) begin
                    sr[0] <= a_in_q[r];
                    for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
                end
            end
            assign row_a[r] = sr[r-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [DW-1:0] a_src;
            logic signed [AW-1:0] p_src;
            if (c == 0) begin : g_a0
                assign a_src = row_a[r];
            end else begin : g_an
                assign a_src = ah[r][c-1];
            end
            if (r == 0) begin : g_p0
                assign p_src = '0;
            end else begin : g_pn
                assign p_src = ps[r-1][c];
            end
            ws_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk      (clk),
                .rst      (rst),
                .en       (adv),
                .w_we     (w_fire && (wrow == CW'(r))),
                .w_in     (bus.w_data[c*DW +: DW]),
                .a_in     (a_src),
                .psum_in  (p_src),
                .a_out    (ah[r][c]),
                .psum_out (ps[r][c])
            );
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_out
        localparam int D = COLS - 1 - c;
        logic signed [63:0] rq;
        if (D == 0) begin : g_direct
            assign col_acc[c] = ps[ROWS-1][c];
        end else begin : g_delay
            logic signed [AW-1:0] dr [D];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) dr[i] <= '0;
                end else if (adv) begin
                    dr[0] <= ps[ROWS-1][c];
                    for (int i = 1; i < D; i++) dr[i] <= dr[i-1];
                end
            end
            assign col_acc[c] = dr[D-1];
        end
        always_comb begin
            rq = requant(longint'(col_acc[c]), 32'(shift_q), OW);
`ifdef SYSTOLIC_RELU_EN
            if (rq < 0) rq = '0;
`endif
        end
        assign y_nxt[c*OW +: OW] = OW'(rq);
    end
endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed bench for systolic_array_ws: dot-product reference model plus literal expectations.
module tb_systolic_array_ws;
    localparam int ROWS = 4, COLS = 4, DW = 8, AW = 24, OW = 8, SHW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_array_ws_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .OW(OW), .SHW(SHW)) bus ();
    systolic_array_ws #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .OW(OW), .SHW(SHW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt = 0, chk_cnt = 0, cyc = 0;
    logic [31:0] w_rows [ROWS];
    int          shift_model = 0;
    logic [32:0] exp_q [$];
    logic [32:0] exp_e;
    logic [31:0] y_log [256];
    logic        ylast_log [256];
    int          y_cyc [256];
    int          acc_cyc [256];
    int          log_n = 0, acc_n = 0;
    logic        rnd_mode = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] held = '0;
    int          y0, a0, n0;

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
    endfunction

    // y[c] = sat(sum_r a[r]*w[r][c] >>> shift)
    function automatic logic [31:0] model_y(input logic [31:0] a, input int sh);
        logic [31:0] y;
        longint s;
        y = '0;
        for (int c = 0; c < COLS; c++) begin
            s = 0;
            for (int r = 0; r < ROWS; r++)
                s += longint'(signed'(a[r*8 +: 8])) * longint'(signed'(w_rows[r][c*8 +: 8]));
            s = s >>> sh;
            if (s > 127) s = 127;
            else if (s < -128) s = -128;
`ifdef SYSTOLIC_RELU_EN
            if (s < 0) s = 0;
`endif
            y[c*8 +: 8] = s[7:0];
        end
        return y;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.a_valid && bus.a_ready) begin
            exp_q.push_back({bus.a_last, model_y(bus.a_data, shift_model)});
            if (acc_n < 256) acc_cyc[acc_n] = cyc + 1;
            acc_n++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("y_hold_valid", bus.y_valid, 1);
                check("y_hold_data", bus.y_data, held);
            end
            if (bus.y_valid && !bus.y_ready) check("a_ready_stalled", bus.a_ready, 0);
            if (bus.y_valid && bus.y_ready) begin
                if (exp_q.size() == 0) begin
                    check("y_unexpected", bus.y_valid, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("y_data", bus.y_data, exp_e[31:0]);
                    check("y_last", bus.y_last, exp_e[32]);
                end
                if (log_n < 256) begin
                    y_log[log_n]     = bus.y_data;
                    ylast_log[log_n] = bus.y_last;
                    y_cyc[log_n]     = cyc;
                end
                log_n++;
            end
            stall_prev = bus.y_valid && !bus.y_ready;
            held       = bus.y_data;
        end
    end

    initial begin
        bus.y_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.y_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic load_w(input int sh);
        logic ok;
        shift_model   = sh;
        bus.cfg_shift = SHW'(sh);
        for (int r = 0; r < ROWS; r++) begin
            bus.w_valid = 1'b1;
            bus.w_data  = w_rows[r];
            ok = 1'b0;
            for (int k = 0; k < 100 && !ok; k++) begin
                @(negedge clk);
                ok = bus.w_ready;
                @(posedge clk);
                #1;
            end
            check("w_accept", ok, 1);
        end
        bus.w_valid   = 1'b0;
        bus.cfg_shift = ~SHW'(sh);
    endtask

    task automatic send_a(input logic [31:0] d, input logic last);
        logic ok;
        bus.a_valid = 1'b1;
        bus.a_data  = d;
        bus.a_last  = last;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            ok = bus.a_ready;
            @(posedge clk);
            #1;
        end
        bus.a_valid = 1'b0;
        bus.a_last  = 1'b0;
        check("a_accept", ok, 1);
    endtask

    task automatic wait_done(input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            done = !bus.busy && (exp_q.size() == 0);
        end
        check(name, done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_identity();
        for (int r = 0; r < ROWS; r++) begin
            w_rows[r] = '0;
            w_rows[r][r*8 +: 8] = 8'd1;
        end
    endtask

    task automatic set_random_w();
        for (int r = 0; r < ROWS; r++) w_rows[r] = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_shift = '0;
        bus.w_valid   = 1'b0;
        bus.w_data    = '0;
        bus.a_valid   = 1'b0;
        bus.a_data    = '0;
        bus.a_last    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_w_ready", bus.w_ready, 1);
        check("rst_a_ready", bus.a_ready, 0);
        check("rst_y_valid", bus.y_valid, 0);
        check("rst_y_last", bus.y_last, 0);
        check("rst_y_data", bus.y_data, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Identity weights
        set_identity();
        load_w(0);
        a0 = acc_n; y0 = log_n;
        send_a(pack4(1, 2, 3, 4), 1'b0);
        send_a(pack4(-5, 6, -7, 8), 1'b1);
        wait_done("t1_done");
        check("t1_beats", log_n - y0, 2);
        check("t1_y0", y_log[y0], 32'h04030201);
`ifdef SYSTOLIC_RELU_EN
        check("t1_y1", y_log[y0+1], 32'h08000600);
`else
        check("t1_y1", y_log[y0+1], 32'h08F906FB);
`endif
        check("t1_last0", ylast_log[y0], 0);
        check("t1_last1", ylast_log[y0+1], 1);
        check("t1_latency", y_cyc[y0] - acc_cyc[a0], ROWS + COLS);

        // Saturation both ways, then shift
        for (int r = 0; r < ROWS; r++) w_rows[r] = 32'h7F7F7F7F;
        load_w(0);
        y0 = log_n;
        send_a(32'h7F7F7F7F, 1'b0);
        send_a(32'h80808080, 1'b1);
        wait_done("t2_done");
        check("t2_beats", log_n - y0, 2);
        check("t2_pos_sat", y_log[y0], 32'h7F7F7F7F);
`ifdef SYSTOLIC_RELU_EN
        check("t2_neg_sat", y_log[y0+1], 32'h00000000);
`else
        check("t2_neg_sat", y_log[y0+1], 32'h80808080);
`endif
        load_w(7);
        y0 = log_n;
        send_a(32'h01010101, 1'b1);
        wait_done("t2s_done");
        check("t2_shift7", y_log[y0], 32'h03030303);

        // Back-to-back vectors under random backpressure
        set_random_w();
        load_w(3);
        rnd_mode = 1'b1;
        y0 = log_n;
        for (int i = 0; i < 16; i++) send_a($urandom, i == 15);
        wait_done("t3_done");
        rnd_mode = 1'b0;
        check("t3_beats", log_n - y0, 16);
        check("t3_last", ylast_log[y0+15], 1);

        // Bubbles: valid pattern 1,0,0,1,1
        set_random_w();
        load_w(2);
        y0 = log_n;
        send_a($urandom, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send_a($urandom, 1'b0);
        send_a($urandom, 1'b1);
        wait_done("t4_done");
        check("t4_beats", log_n - y0, 3);
        check("t4_last", ylast_log[y0+2], 1);

        // Reset in the middle of a job
        set_random_w();
        load_w(1);
        for (int i = 0; i < 3; i++) send_a($urandom, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_y_valid", bus.y_valid, 0);
        check("t5_busy", bus.busy, 0);
        check("t5_w_ready", bus.w_ready, 1);
        n0 = log_n;
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_y", log_n - n0, 0);
        set_random_w();
        load_w(0);
        y0 = log_n;
        send_a($urandom, 1'b0);
        send_a($urandom, 1'b0);
        send_a($urandom, 1'b1);
        wait_done("t5_done");
        check("t5_beats", log_n - y0, 3);

        // Negative outputs: ReLU on/off
        set_identity();
        load_w(0);
        y0 = log_n;
        send_a(pack4(-3, 3, -1, 0), 1'b1);
        wait_done("t6_done");
`ifdef SYSTOLIC_RELU_EN
        check("t6_relu", y_log[y0], 32'h00000300);
`else
        check("t6_signed", y_log[y0], 32'h00FF03FD);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
